// File: rtl/tile_scroller.sv
// Tile scroller game controller: four rows of falling tiles, an LFSR
// picking new tile columns, a handshake with an external tile drawer,
// and a timeout that ends the game if the player waits too long.
module tile_scroller #(
  parameter int         TIMEOUT_TICKS = 60,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       tick,
  input  logic [3:0] key,
  input  logic       draw_done,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [6:0] y1,
  output logic [6:0] y2,
  output logic [6:0] y3,
  output logic [6:0] y4,
  output logic       draw_start,
  output logic [7:0] score,
  output logic       playing,
  output logic       game_over
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DRAW_START,
    S_DRAW_WAIT,
    S_PLAY,
    S_SHIFT,
    S_OVER
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      lfsr;
  logic [1:0]      col0;
  logic [1:0]      col1;
  logic [1:0]      col2;
  logic [1:0]      col3;
  logic [1:0]      init_cnt;
  logic [TW-1:0]   timeout_cnt;
  logic [3:0]      key_prev;
  logic [3:0]      edges;
  logic            hit_ok;
  logic            hit_bad;
  logic            last_tick;

  // Screen x position of a tile in a given column (columns are 40 pixels apart).
  function automatic logic [7:0] col_to_x(input logic [1:0] c);
    return 8'(c) * 8'd40 + 8'd1;
  endfunction

  // Rows sit at fixed heights; only their columns move.
  assign y1 = 7'd90;
  assign y2 = 7'd60;
  assign y3 = 7'd30;
  assign y4 = 7'd0;

  assign draw_start = (state == S_DRAW_START);
  assign playing    = (state == S_PLAY);
  assign game_over  = (state == S_OVER);

  // Classify this cycle's key presses: exactly the bottom tile's key is a hit,
  // anything else pressed is a miss; also flag the tick that runs out the clock.
  always_comb begin
    edges     = key & ~key_prev;
    hit_ok    = (edges == (4'b0001 << col0));
    hit_bad   = (edges != 4'b0000) && !hit_ok;
    last_tick = tick && (timeout_cnt == TW'(TIMEOUT_TICKS - 1));
  end

  // State register; reset abandons any game in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic. A correct hit takes priority over the final timeout tick.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (go) next_state = S_INIT;
      S_INIT:       if (init_cnt == 2'd3) next_state = S_DRAW_START;
      S_DRAW_START: next_state = S_DRAW_WAIT;
      S_DRAW_WAIT:  if (draw_done) next_state = S_PLAY;
      S_PLAY: begin
        if (hit_ok)         next_state = S_SHIFT;
        else if (hit_bad)   next_state = S_OVER;
        else if (last_tick) next_state = S_OVER;
      end
      S_SHIFT:      next_state = S_DRAW_START;
      S_OVER:       if (go) next_state = S_INIT;
      default:      next_state = S_IDLE;
    endcase
  end

  // Free-running Fibonacci LFSR (taps 8,6,5,4); never reseeded except by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Previous key levels for rising-edge detection, tracked in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) key_prev <= 4'b0000;
    else         key_prev <= key;
  end

  // Counts the four row-loading cycles of initialisation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               init_cnt <= 2'd0;
    else if (state == S_INIT)  init_cnt <= init_cnt + 2'd1;
    else                       init_cnt <= 2'd0;
  end

  // Row columns and their x positions; loaded one row per init cycle, shifted down on a hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col0 <= 2'd0;
      col1 <= 2'd0;
      col2 <= 2'd0;
      col3 <= 2'd0;
      x1   <= 8'd1;
      x2   <= 8'd1;
      x3   <= 8'd1;
      x4   <= 8'd1;
    end else if (state == S_INIT) begin
      case (init_cnt)
        2'd0: begin col0 <= lfsr[1:0]; x1 <= col_to_x(lfsr[1:0]); end
        2'd1: begin col1 <= lfsr[1:0]; x2 <= col_to_x(lfsr[1:0]); end
        2'd2: begin col2 <= lfsr[1:0]; x3 <= col_to_x(lfsr[1:0]); end
        default: begin col3 <= lfsr[1:0]; x4 <= col_to_x(lfsr[1:0]); end
      endcase
    end else if (state == S_SHIFT) begin
      col0 <= col1;
      col1 <= col2;
      col2 <= col3;
      col3 <= lfsr[1:0];
      x1   <= x2;
      x2   <= x3;
      x3   <= x4;
      x4   <= col_to_x(lfsr[1:0]);
    end
  end

  // Score: cleared on (re)start, saturating increment on each correct hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 score <= 8'd0;
    else if (state == S_INIT)                    score <= 8'd0;
    else if (state == S_SHIFT && score != 8'hFF) score <= score + 8'd1;
  end

  // Ticks spent waiting in play; restarts for every new bottom tile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             timeout_cnt <= '0;
    else if (state == S_INIT || state == S_SHIFT) timeout_cnt <= '0;
    else if (state == S_PLAY && tick)        timeout_cnt <= timeout_cnt + TW'(1);
  end

endmodule

// File: tb/tb_tile_scroller.sv
// Self-checking bench for tile_scroller: an LFSR reference model predicts
// tile columns, expected row/score snapshots are queued when stimulus is
// applied and compared when the DUT raises draw_start.
module tb_tile_scroller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] key = 4'b0000;
  logic       draw_done = 1'b0;
  logic [7:0] x1, x2, x3, x4;
  logic [6:0] y1, y2, y3, y4;
  logic       draw_start;
  logic [7:0] score;
  logic       playing;
  logic       game_over;

  typedef struct {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x4;
    logic [7:0] score;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m;
  logic [1:0] exp_col[4];
  logic [7:0] score_exp;

  tile_scroller dut (
    .clk(clk), .resetn(resetn), .go(go), .tick(tick), .key(key),
    .draw_done(draw_done),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .draw_start(draw_start), .score(score),
    .playing(playing), .game_over(game_over)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int pos(input logic [1:0] c);
    return int'(c) * 40 + 1;
  endfunction

  // Reference LFSR stepping once per clock from the seed.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= 8'hA5;
    else         m <= lfsr_next(m);
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.x1    = 8'(pos(exp_col[0]));
    e.x2    = 8'(pos(exp_col[1]));
    e.x3    = 8'(pos(exp_col[2]));
    e.x4    = 8'(pos(exp_col[3]));
    e.score = score_exp;
    sb.push_back(e);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " x1"}, x1, 1);
    checkOutput({tag, " x2"}, x2, 1);
    checkOutput({tag, " x3"}, x3, 1);
    checkOutput({tag, " x4"}, x4, 1);
    checkOutput({tag, " y1"}, y1, 90);
    checkOutput({tag, " y2"}, y2, 60);
    checkOutput({tag, " y3"}, y3, 30);
    checkOutput({tag, " y4"}, y4, 0);
    checkOutput({tag, " draw_start"}, draw_start, 0);
    checkOutput({tag, " playing"}, playing, 0);
    checkOutput({tag, " game_over"}, game_over, 0);
    checkOutput({tag, " score"}, score, 0);
  endtask

  // Waits (bounded) for draw_start, compares against the queued snapshot,
  // then completes the drawer handshake and confirms entry into play.
  task automatic waitDraw(input string tag, output int waited);
    exp_t e;
    waited = 0;
    while (!draw_start && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!draw_start) begin
      checkOutput({tag, " draw_start timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, " unexpected draw_start"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, " x1"}, x1, e.x1);
    checkOutput({tag, " x2"}, x2, e.x2);
    checkOutput({tag, " x3"}, x3, e.x3);
    checkOutput({tag, " x4"}, x4, e.x4);
    checkOutput({tag, " score"}, score, e.score);
    @(negedge clk);
    checkOutput({tag, " draw_start width"}, draw_start, 0);
    checkOutput({tag, " playing before done"}, playing, 0);
    @(negedge clk);
    checkOutput({tag, " still waiting"}, playing, 0);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    checkOutput({tag, " playing after done"}, playing, 1);
  endtask

  // Requests a (re)start from idle or game over and checks the first draw.
  task automatic startGame(input string tag);
    logic [7:0] v;
    int         w;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    v = m;
    for (int i = 0; i < 4; i++) begin
      exp_col[i] = v[1:0];
      v = lfsr_next(v);
    end
    score_exp = 8'd0;
    pushExpected();
    waitDraw(tag, w);
    checkOutput({tag, " go->draw_start latency"}, w + 1, 5);
  endtask

  // Presses the bottom tile's key; optionally on the same cycle as a tick,
  // optionally leaving the key held afterwards.
  task automatic applyStimulus(input string tag, input bit hold, input bit with_tick);
    int w;
    @(negedge clk);
    key = 4'b0001 << exp_col[0];
    tick = with_tick;
    @(negedge clk);
    tick = 1'b0;
    checkOutput({tag, " no game over on hit"}, game_over, 0);
    exp_col[0] = exp_col[1];
    exp_col[1] = exp_col[2];
    exp_col[2] = exp_col[3];
    exp_col[3] = m[1:0];
    if (score_exp != 8'hFF) score_exp = score_exp + 8'd1;
    pushExpected();
    if (!hold) key = 4'b0000;
    waitDraw(tag, w);
  endtask

  task automatic pressMiss(input string tag, input logic [3:0] pattern);
    @(negedge clk);
    key = pattern;
    @(negedge clk);
    key = 4'b0000;
    checkOutput({tag, " game_over"}, game_over, 1);
    checkOutput({tag, " playing"}, playing, 0);
    checkOutput({tag, " score frozen"}, score, score_exp);
    checkOutput({tag, " x1 frozen"}, x1, pos(exp_col[0]));
  endtask

  task automatic sendTicks(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] p;
    int         ds_seen;
    int         w;

    repeat (3) @(negedge clk);
    checkIdleOutputs("in reset");
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    checkIdleOutputs("idle 10 cycles");

    startGame("start1");
    applyStimulus("hit1", 1'b0, 1'b0);
    applyStimulus("hit2", 1'b0, 1'b0);
    applyStimulus("hit3", 1'b0, 1'b0);

    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checkOutput("go ignored in play", playing, 1);
    checkOutput("go ignored x1", x1, pos(exp_col[0]));

    p = 4'b0001 << (exp_col[0] + 2'd1);
    pressMiss("wrong key", p);
    repeat (3) @(negedge clk);
    checkOutput("over score held", score, 3);

    startGame("restart");
    applyStimulus("held hit", 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("held key no 2nd edge score", score, score_exp);
    checkOutput("held key still playing", playing, 1);
    @(negedge clk);
    key = 4'b0000;
    @(negedge clk);
    checkOutput("release still playing", playing, 1);
    p = (4'b0001 << exp_col[0]) | (4'b0001 << (exp_col[0] + 2'd1));
    pressMiss("two keys", p);

    startGame("sat start");
    repeat (260) applyStimulus("sat hit", 1'b0, 1'b0);
    checkOutput("score saturated", score, 255);
    sendTicks(59);
    checkOutput("59 ticks playing", playing, 1);
    sendTicks(1);
    checkOutput("60th tick game_over", game_over, 1);
    checkOutput("timeout score frozen", score, 255);

    startGame("tick race start");
    sendTicks(59);
    applyStimulus("hit on 60th tick", 1'b0, 1'b1);
    sendTicks(59);
    checkOutput("counter cleared by hit", playing, 1);
    sendTicks(1);
    checkOutput("timeout after hit", game_over, 1);

    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    w = 0;
    while (!draw_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("pre-reset draw_start", draw_start, 1);
    @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    checkIdleOutputs("async reset in draw wait");
    ds_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (draw_start) ds_seen++;
    end
    checkOutput("no draw_start in reset", ds_seen, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleOutputs("after reset release");
    startGame("post reset start");
    applyStimulus("post reset hit", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
